// File: rtl/stdp_synapse_array.sv
// stdp_synapse_array
//   N_PRE leaky integrate-and-fire presynaptic neurons driven by one shared
//   current, each with its own threshold, feeding one postsynaptic LIF neuron
//   through saturating per-synapse weights. Pair-based STDP nudges each weight
//   up (pre before post) or down (post before pre) when the pairing falls
//   inside a programmable window.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_current    current into every presynaptic neuron
//   pre_thresh    per-channel thresholds, channel i at [i*V_BITS +: V_BITS]
//   stdp_window   pairing window in cycles (0 disables learning)
//   learn_en      weight update enable
//   pre_spike     registered presynaptic spikes
//   post_spike    registered postsynaptic spike
//   post_state    postsynaptic membrane potential
//   weights       weight i at [i*W_BITS +: W_BITS]
//   update_pulse  one-cycle pulse after any weight actually changed

// One presynaptic channel: LIF neuron, spike timer and its synapse weight.
module stdp_lane #(
  parameter int V_BITS     = 8,
  parameter int W_BITS     = 4,
  parameter int T_BITS     = 4,
  parameter int W_INIT     = 8,
  parameter int LEAK_SHIFT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [V_BITS-1:0] cur,
  input  logic [V_BITS-1:0] thresh,
  input  logic              post_spike,
  input  logic [T_BITS-1:0] post_timer,
  input  logic [T_BITS-1:0] stdp_window,
  input  logic              learn_en,
  output logic              pre_spike,
  output logic [W_BITS-1:0] w,
  output logic              w_change
);
  localparam int SW = V_BITS + 2;
  localparam logic [SW-1:0] V_MAX = {2'b00, {V_BITS{1'b1}}};

  logic [V_BITS-1:0] v_q, v_d;
  logic              spike_q, spike_d;
  logic [T_BITS-1:0] timer_q, timer_d;
  logic [W_BITS-1:0] w_q, w_d;
  logic [SW-1:0]     sum;
  logic              ltp, ltd;

  always_comb begin
    sum = SW'(v_q) - SW'(v_q >> LEAK_SHIFT) + SW'(cur);
    if (sum > V_MAX) sum = V_MAX;
    spike_d = (sum >= SW'(thresh));
    v_d     = spike_d ? '0 : sum[V_BITS-1:0];
    // Timer holds cycles-since-spike minus one, parked at all-ones.
    timer_d = spike_q ? '0 : (timer_q == '1) ? timer_q : timer_q + T_BITS'(1);
    // A coincident pre/post pair satisfies neither rule. Saturated no-ops
    // are excluded here so they never raise the update pulse.
    ltp = learn_en && post_spike && !spike_q && (timer_q < stdp_window) && (w_q != '1);
    ltd = learn_en && spike_q && !post_spike && (post_timer < stdp_window) && (w_q != '0);
    w_d = ltp ? w_q + W_BITS'(1) : ltd ? w_q - W_BITS'(1) : w_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      spike_q <= 1'b0;
      timer_q <= '1;
      w_q     <= W_BITS'(W_INIT);
    end else begin
      v_q     <= v_d;
      spike_q <= spike_d;
      timer_q <= timer_d;
      w_q     <= w_d;
    end
  end

  assign pre_spike = spike_q;
  assign w         = w_q;
  assign w_change  = ltp | ltd;
endmodule

module stdp_synapse_array #(
  parameter int N_PRE           = 4,
  parameter int V_BITS          = 8,
  parameter int W_BITS          = 4,
  parameter int T_BITS          = 4,
  parameter int W_INIT          = 8,
  parameter int LEAK_SHIFT      = 1,
  parameter int POST_GAIN_SHIFT = 2,
  parameter int POST_THRESH     = 200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                in_current,
  input  logic [N_PRE*V_BITS-1:0]   pre_thresh,
  input  logic [T_BITS-1:0]         stdp_window,
  input  logic                      learn_en,
  output logic [N_PRE-1:0]          pre_spike,
  output logic                      post_spike,
  output logic [V_BITS-1:0]         post_state,
  output logic [N_PRE*W_BITS-1:0]   weights,
  output logic                      update_pulse
);
  localparam int SW     = V_BITS + 2;
  localparam int CW     = (V_BITS > 8) ? V_BITS : 8;
  localparam int PW_RAW = W_BITS + 4 + POST_GAIN_SHIFT;
  localparam int PW     = (PW_RAW > V_BITS) ? PW_RAW : V_BITS;
  localparam logic [SW-1:0] V_MAX = {2'b00, {V_BITS{1'b1}}};

  logic [N_PRE-1:0][W_BITS-1:0] w;
  logic [N_PRE-1:0]             pre_spk, w_chg;
  logic [CW-1:0]                in_ext;
  logic [V_BITS-1:0]            pre_cur, post_cur;
  logic [PW-1:0]                w_sum, post_cur_w;
  logic [SW-1:0]                post_sum;

  logic [V_BITS-1:0] post_v_q, post_v_d;
  logic              post_spike_q, post_spike_d;
  logic [T_BITS-1:0] post_timer_q, post_timer_d;
  logic              upd_q, upd_d;

  // Shared current fitted to V_BITS: zero-extend when wider, clamp when narrower.
  always_comb begin
    in_ext  = CW'(in_current);
    pre_cur = (in_ext > CW'({V_BITS{1'b1}})) ? '1 : in_ext[V_BITS-1:0];
  end

  for (genvar i = 0; i < N_PRE; i++) begin : g_lane
    stdp_lane #(
      .V_BITS(V_BITS), .W_BITS(W_BITS), .T_BITS(T_BITS),
      .W_INIT(W_INIT), .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .cur        (pre_cur),
      .thresh     (pre_thresh[i*V_BITS +: V_BITS]),
      .post_spike (post_spike_q),
      .post_timer (post_timer_q),
      .stdp_window(stdp_window),
      .learn_en   (learn_en),
      .pre_spike  (pre_spk[i]),
      .w          (w[i]),
      .w_change   (w_chg[i])
    );
  end

  // Post neuron sees last cycle's registered pre spikes, weighted and gained.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_PRE; i++)
      if (pre_spk[i]) w_sum = w_sum + PW'(w[i]);
    post_cur_w = w_sum << POST_GAIN_SHIFT;
    post_cur   = (post_cur_w > PW'({V_BITS{1'b1}})) ? '1 : post_cur_w[V_BITS-1:0];

    post_sum = SW'(post_v_q) - SW'(post_v_q >> LEAK_SHIFT) + SW'(post_cur);
    if (post_sum > V_MAX) post_sum = V_MAX;
    post_spike_d = (post_sum >= SW'(POST_THRESH));
    post_v_d     = post_spike_d ? '0 : post_sum[V_BITS-1:0];
    post_timer_d = post_spike_q ? '0 :
                   (post_timer_q == '1) ? post_timer_q : post_timer_q + T_BITS'(1);
    upd_d        = |w_chg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_v_q     <= '0;
      post_spike_q <= 1'b0;
      post_timer_q <= '1;
      upd_q        <= 1'b0;
    end else begin
      post_v_q     <= post_v_d;
      post_spike_q <= post_spike_d;
      post_timer_q <= post_timer_d;
      upd_q        <= upd_d;
    end
  end

  assign pre_spike    = pre_spk;
  assign post_spike   = post_spike_q;
  assign post_state   = post_v_q;
  assign weights      = w;
  assign update_pulse = upd_q;
endmodule

// File: tb/tb_stdp_synapse_array.sv
// Directed bench for stdp_synapse_array with default parameters.
// Pre channels 1..3 (threshold 1, current 100) spike every cycle and hold the
// post neuron at 192; a single channel-0 spike then pushes it over 200, which
// gives exactly placed pre/post pairings. learn_en is opened for single edges
// so only the pairing under test can move a weight.
module tb_stdp_synapse_array;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_current;
  logic [31:0] pre_thresh;
  logic [3:0]  stdp_window;
  logic        learn_en;
  logic [3:0]  pre_spike;
  logic        post_spike;
  logic [7:0]  post_state;
  logic [15:0] weights;
  logic        update_pulse;

  int errs = 0;
  int checks = 0;

  stdp_synapse_array dut (
    .clk(clk), .rst_n(rst_n), .in_current(in_current), .pre_thresh(pre_thresh),
    .stdp_window(stdp_window), .learn_en(learn_en), .pre_spike(pre_spike),
    .post_spike(post_spike), .post_state(post_state), .weights(weights),
    .update_pulse(update_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_th(input logic [7:0] t3, input logic [7:0] t2,
                        input logic [7:0] t1, input logic [7:0] t0);
    pre_thresh = {t3, t2, t1, t0};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel-0 trigger on a post neuron held at 192: post fires the cycle
  // after ch0 spikes, with ch0 silent and its timer at 0. learn_en is open
  // only for the edge that evaluates that post spike.
  task automatic pair_ltp(input logic le);
    set_th(1, 1, 1, 100);
    tick();
    chk("ltp_trig_pre", pre_spike, 4'hF);
    set_th(1, 1, 1, 255);
    tick();
    chk("ltp_post_fire", post_spike, 1'b1);
    learn_en = le;
    tick();
    learn_en = 1'b0;
  endtask

  task automatic restart_primed();
    rst_n = 1'b0;
    in_current = 8'd100;
    set_th(1, 1, 1, 255);
    stdp_window = 4'd4;
    learn_en = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
  endtask

  initial begin
    logic [7:0] exp_post [1:6];
    logic [3:0] ew;
    logic       eu;
    exp_post = '{8'd0, 8'd0, 8'd32, 8'd16, 8'd40, 8'd20};

    // Reset with every input active.
    rst_n = 1'b0;
    in_current = 8'd255;
    pre_thresh = '0;
    stdp_window = 4'd4;
    learn_en = 1'b1;
    repeat (3) tick();
    chk("rst_weights", weights, 16'h8888);
    chk("rst_pre_spike", pre_spike, 4'h0);
    chk("rst_post_spike", post_spike, 1'b0);
    chk("rst_post_state", post_state, 8'd0);
    chk("rst_update", update_pulse, 1'b0);

    // LIF timing: ch0 goes 100, then spikes (150 >= 140) every 2nd cycle.
    in_current = 8'd100;
    set_th(255, 255, 255, 140);
    learn_en = 1'b0;
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("lif_pre_spike", pre_spike, (c % 2 == 0) ? 4'h1 : 4'h0);
      chk("lif_post_state", post_state, exp_post[c]);
    end

    // Asynchronous mid-run reset, sampled before any further edge.
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_weights", weights, 16'h8888);
    chk("mid_rst_pre_spike", pre_spike, 4'h0);
    chk("mid_rst_post_state", post_state, 8'd0);

    // Saturation: membranes near 200, then current 255 -> clamp at 255 spikes.
    in_current = 8'd100;
    set_th(255, 255, 255, 255);
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("sat_quiet", pre_spike, 4'h0);
    in_current = 8'd255;
    tick();
    chk("sat_clamp_spike", pre_spike, 4'hF);
    tick();
    chk("sat_from_zero", pre_spike, 4'hF);

    // LTP repeated to the upper bound.
    restart_primed();
    chk("prime_post_state", post_state, 8'd192);
    chk("prime_pre_spike", pre_spike, 4'hE);
    ew = 4'd8;
    for (int r = 0; r < 10; r++) begin
      pair_ltp(1'b1);
      if (ew != 4'hF) begin ew = ew + 4'd1; eu = 1'b1; end
      else eu = 1'b0;
      chk("ltp_weights", weights, {12'h888, ew});
      chk("ltp_update", update_pulse, eu);
      tick();
      chk("ltp_update_drop", update_pulse, 1'b0);
      repeat (8) tick();
    end

    // Coincident pre0/post, then window 0, learn_en 0, and window 1.
    restart_primed();
    set_th(1, 1, 1, 100);
    tick();
    tick();
    chk("sim_post_fire", post_spike, 1'b1);
    chk("sim_pre_spike", pre_spike, 4'hF);
    set_th(1, 1, 1, 255);
    learn_en = 1'b1;
    tick();
    learn_en = 1'b0;
    chk("sim_weights", weights, 16'h8888);
    chk("sim_update", update_pulse, 1'b0);
    repeat (10) tick();

    stdp_window = 4'd0;
    pair_ltp(1'b1);
    chk("win0_weights", weights, 16'h8888);
    chk("win0_update", update_pulse, 1'b0);
    repeat (9) tick();

    stdp_window = 4'd4;
    pair_ltp(1'b0);
    chk("noln_weights", weights, 16'h8888);
    chk("noln_update", update_pulse, 1'b0);
    repeat (9) tick();

    stdp_window = 4'd1;
    pair_ltp(1'b1);
    chk("win1_weights", weights, 16'h8889);
    chk("win1_update", update_pulse, 1'b1);

    // LTD: post fires at P, drivers silenced, ch0 spikes at P+2, P+4, P+5.
    restart_primed();
    set_th(1, 1, 1, 100);
    tick();
    set_th(255, 255, 255, 255);
    tick();
    chk("ltd_post_fire", post_spike, 1'b1);
    tick();
    learn_en = 1'b1;
    set_th(255, 255, 255, 100);
    tick();
    chk("ltd_pre_p2", pre_spike, 4'h1);
    set_th(255, 255, 255, 255);
    tick();
    chk("ltd_t1_weights", weights, 16'h8887);
    chk("ltd_t1_update", update_pulse, 1'b1);
    set_th(255, 255, 255, 100);
    tick();
    chk("ltd_p4_update", update_pulse, 1'b0);
    chk("ltd_pre_p4", pre_spike, 4'h1);
    tick();
    chk("ltd_t3_weights", weights, 16'h8886);
    chk("ltd_t3_update", update_pulse, 1'b1);
    chk("ltd_pre_p5", pre_spike, 4'h1);
    set_th(255, 255, 255, 255);
    tick();
    chk("ltd_t4_weights", weights, 16'h8886);
    chk("ltd_t4_update", update_pulse, 1'b0);

    // LTD down to the lower bound with a wide window.
    stdp_window = 4'd15;
    ew = 4'd6;
    for (int m = 7; m <= 15; m++) begin
      set_th(255, 255, 255, (m <= 14) ? 8'd100 : 8'd255);
      tick();
      if (m >= 8 && ew != 4'd0) begin ew = ew - 4'd1; eu = 1'b1; end
      else eu = 1'b0;
      chk("ltd_floor_weights", weights, {12'h888, ew});
      chk("ltd_floor_update", update_pulse, eu);
    end
    chk("ltd_floor_zero", weights[3:0], 4'd0);

    // Gating: random activity with learning off, then with window 0.
    rst_n = 1'b0;
    learn_en = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      in_current = 8'($urandom);
      pre_thresh = $urandom;
      stdp_window = 4'($urandom);
      tick();
      chk("gate_off_weights", weights, 16'h8888);
      chk("gate_off_update", update_pulse, 1'b0);
    end
    learn_en = 1'b1;
    stdp_window = 4'd0;
    for (int n = 0; n < 300; n++) begin
      in_current = 8'($urandom);
      pre_thresh = $urandom;
      tick();
      chk("gate_win0_weights", weights, 16'h8888);
      chk("gate_win0_update", update_pulse, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
